// File: rtl/tap_pkg.sv
// ---------------------------------------------------------------------------
// tap_pkg
// Shared definitions for the tap write arbiter:
//   - tap_state_e : FSM state encoding (IDLE, CMD, DATA, GAP)
//   - GAP_CYC_MIN/GAP_CYC_MAX : legal range of the inter-transaction gap
//   - GAP_CNT_W   : width of the gap down-counter (covers GAP_CYC_MAX)
//   - STAT_W      : width of the per-requester statistics counters
//   - sat_inc()   : saturating increment used by the statistics counters
// ---------------------------------------------------------------------------
package tap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } tap_state_e;

    localparam int GAP_CYC_MIN = 0;
    localparam int GAP_CYC_MAX = 15;
    localparam int GAP_CNT_W   = 4;
    localparam int STAT_W      = 32;

    // Holds at all-ones instead of wrapping back to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/tap_rr_arb2.sv
// ---------------------------------------------------------------------------
// tap_rr_arb2
// Two-way round-robin grant logic.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-high reset (req0 wins first contention)
//   req    - [1:0] request vector
//   update - grant is being consumed this cycle; advance the priority pointer
//   grant  - [1:0] one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module tap_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // prio_q = 1 means req1 wins the next contention.
    logic prio_q;
    logic prio_d;

    // The pointer only matters when both request; a lone requester is
    // granted regardless of whose turn it is.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = prio_q ? 2'b10 : 2'b01;
        end
    end

    // After serving req0 hand priority to req1 and vice versa.
    always_comb begin
        prio_d = prio_q;
        if (update && (grant != 2'b00)) begin
            prio_d = grant[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/tap_wr_arb.sv
// ---------------------------------------------------------------------------
// tap_wr_arb
// Arbitrates two tap-write requesters onto a single tap write channel.
// Each accepted request produces a one-cycle command strobe carrying the
// address, then a one-cycle data strobe carrying the data, followed by
// GAP_CYC idle cycles before the next request can be accepted.
//
// Parameters:
//   GAP_CYC - idle cycles after each transaction (0..15)
//   AW, DW  - tap address / data width
// Ports:
//   clk_100m, rst_100m         - clock, async active-high reset
//   cfg_clr                    - synchronous clear of statistics counters
//   reqN_vld/addr/data, reqN_rdy - requester N handshake (rdy = accept strobe)
//   tap_wr_cmd/tap_wr_addr     - command strobe and address (zero when idle)
//   tap_wr_vld/tap_wr_data     - data strobe and data (zero when idle)
//   tap_busy                   - FSM not in IDLE
//   grant_id                   - requester of the current/last transaction
//   stat_cnt0/stat_cnt1        - accepted transactions per requester
//
// Build option: define TAP_WR_ARB_STAT_EN to include the statistics
// counters; without it stat_cnt0/stat_cnt1 are constant zero.
// ---------------------------------------------------------------------------
module tap_wr_arb
    import tap_pkg::*;
#(
    parameter int GAP_CYC = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk_100m,
    input  logic          rst_100m,
    input  logic          cfg_clr,
    input  logic          req0_vld,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_rdy,
    input  logic          req1_vld,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_rdy,
    output logic          tap_wr_cmd,
    output logic [AW-1:0] tap_wr_addr,
    output logic          tap_wr_vld,
    output logic [DW-1:0] tap_wr_data,
    output logic          tap_busy,
    output logic          grant_id,
    output logic [31:0]   stat_cnt0,
    output logic [31:0]   stat_cnt1
);

    // GAP state is entered with the counter loaded so that it lasts GAP_CYC cycles.
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD =
        GAP_CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    tap_state_e           state_q, state_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        data_q, data_d;
    logic                 gid_q, gid_d;

    logic [1:0] grant;
    logic       accept;

    // rdy is combinational from state, so it is also qualified with reset
    // to drop the very moment reset is asserted.
    assign accept = (state_q == ST_IDLE) && !rst_100m && (req0_vld || req1_vld);

    tap_rr_arb2 u_rr (
        .clk    (clk_100m),
        .rst    (rst_100m),
        .req    ({req1_vld, req0_vld}),
        .update (accept),
        .grant  (grant)
    );

    assign req0_rdy    = accept && grant[0];
    assign req1_rdy    = accept && grant[1];
    assign tap_wr_cmd  = (state_q == ST_CMD);
    assign tap_wr_addr = tap_wr_cmd ? addr_q : '0;
    assign tap_wr_vld  = (state_q == ST_DATA);
    assign tap_wr_data = tap_wr_vld ? data_q : '0;
    assign tap_busy    = (state_q != ST_IDLE);
    assign grant_id    = gid_q;

    // Requests are only looked at in IDLE; anything arriving later simply
    // waits because the requester keeps vld high until it sees rdy.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        gid_d     = gid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = grant[1] ? req1_addr : req0_addr;
                    data_d  = grant[1] ? req1_data : req0_data;
                    gid_d   = grant[1];
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (GAP_CYC == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100m or posedge rst_100m) begin
        if (rst_100m) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            gid_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            gid_q     <= gid_d;
        end
    end

`ifdef TAP_WR_ARB_STAT_EN
    logic [STAT_W-1:0] stat_cnt0_q, stat_cnt0_d;
    logic [STAT_W-1:0] stat_cnt1_q, stat_cnt1_d;

    // A clear arriving together with an acceptance wins over the increment.
    always_comb begin
        stat_cnt0_d = stat_cnt0_q;
        stat_cnt1_d = stat_cnt1_q;
        if (cfg_clr) begin
            stat_cnt0_d = '0;
            stat_cnt1_d = '0;
        end else begin
            if (req0_rdy) stat_cnt0_d = sat_inc(stat_cnt0_q);
            if (req1_rdy) stat_cnt1_d = sat_inc(stat_cnt1_q);
        end
    end

    always_ff @(posedge clk_100m or posedge rst_100m) begin
        if (rst_100m) begin
            stat_cnt0_q <= '0;
            stat_cnt1_q <= '0;
        end else begin
            stat_cnt0_q <= stat_cnt0_d;
            stat_cnt1_q <= stat_cnt1_d;
        end
    end

    assign stat_cnt0 = stat_cnt0_q;
    assign stat_cnt1 = stat_cnt1_q;
`else
    logic unused_cfg_clr;
    assign unused_cfg_clr = cfg_clr;
    assign stat_cnt0      = '0;
    assign stat_cnt1      = '0;
`endif

endmodule

// File: tb/tb_tap_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_tap_wr_arb
// Two arbiter instances (GAP_CYC=2 and GAP_CYC=0), each with its own
// requesters, compared every cycle against a timeline model: an acceptance
// at cycle N predicts cmd at N+1, data at N+2 and availability again at
// N+3+GAP_CYC.
// ---------------------------------------------------------------------------
module tb_tap_wr_arb;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;
`ifdef TAP_WR_ARB_STAT_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic clk_100m = 1'b0;
    logic rst_100m = 1'b1;
    always #5 clk_100m = ~clk_100m;

    // Per-instance stimulus (index k) and per-requester payload (index r)
    logic          cfg_clr  [2];
    logic [1:0]    req_vld  [2];
    logic [AW-1:0] req_addr [2][2];
    logic [DW-1:0] req_data [2][2];

    logic          rdy0_o [2], rdy1_o [2], cmd_o [2], vld_o [2], busy_o [2], gid_o [2];
    logic [AW-1:0] addr_o [2];
    logic [DW-1:0] data_o [2];
    logic [31:0]   stat0_o [2], stat1_o [2];

    tap_wr_arb #(.GAP_CYC(GAP_A), .AW(AW), .DW(DW)) u_dut_a (
        .clk_100m(clk_100m), .rst_100m(rst_100m), .cfg_clr(cfg_clr[0]),
        .req0_vld(req_vld[0][0]), .req0_addr(req_addr[0][0]), .req0_data(req_data[0][0]), .req0_rdy(rdy0_o[0]),
        .req1_vld(req_vld[0][1]), .req1_addr(req_addr[0][1]), .req1_data(req_data[0][1]), .req1_rdy(rdy1_o[0]),
        .tap_wr_cmd(cmd_o[0]), .tap_wr_addr(addr_o[0]), .tap_wr_vld(vld_o[0]), .tap_wr_data(data_o[0]),
        .tap_busy(busy_o[0]), .grant_id(gid_o[0]), .stat_cnt0(stat0_o[0]), .stat_cnt1(stat1_o[0])
    );

    tap_wr_arb #(.GAP_CYC(GAP_B), .AW(AW), .DW(DW)) u_dut_b (
        .clk_100m(clk_100m), .rst_100m(rst_100m), .cfg_clr(cfg_clr[1]),
        .req0_vld(req_vld[1][0]), .req0_addr(req_addr[1][0]), .req0_data(req_data[1][0]), .req0_rdy(rdy0_o[1]),
        .req1_vld(req_vld[1][1]), .req1_addr(req_addr[1][1]), .req1_data(req_data[1][1]), .req1_rdy(rdy1_o[1]),
        .tap_wr_cmd(cmd_o[1]), .tap_wr_addr(addr_o[1]), .tap_wr_vld(vld_o[1]), .tap_wr_data(data_o[1]),
        .tap_busy(busy_o[1]), .grant_id(gid_o[1]), .stat_cnt0(stat0_o[1]), .stat_cnt1(stat1_o[1])
    );

    // Reference model state, one set per instance
    int            cyc = 0;
    int            acc_cyc   [2];
    int            next_free [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    logic          m_prio [2];
    logic          m_gid  [2];
    logic [31:0]   m_cnt0 [2], m_cnt1 [2];
    logic [1:0]    m_acc  [2];

    int errors = 0;
    int checks = 0;
    int mode   = 3;   // 0 random, 1 both held, 2 req1 held, 3 no new requests

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic modelReset(input int k);
        acc_cyc[k]   = -100;
        next_free[k] = 0;
        m_addr[k]    = '0;
        m_data[k]    = '0;
        m_prio[k]    = 1'b0;
        m_gid[k]     = 1'b0;
        m_cnt0[k]    = '0;
        m_cnt1[k]    = '0;
        m_acc[k]     = 2'b00;
    endtask

    // Evaluate one instance for the current cycle, compare, then advance.
    task automatic modelStep(input int k);
        string      p;
        int         gap;
        logic       acc, g, e_cmd, e_vld, e_busy;
        logic [1:0] v;
        p   = (k == 0) ? "a." : "b.";
        gap = (k == 0) ? GAP_A : GAP_B;
        if (rst_100m) begin
            modelReset(k);
            checkOutput({p, "rst_rdy0"}, 64'(rdy0_o[k]), 64'd0);
            checkOutput({p, "rst_rdy1"}, 64'(rdy1_o[k]), 64'd0);
            checkOutput({p, "rst_cmd"},  64'(cmd_o[k]),  64'd0);
            checkOutput({p, "rst_vld"},  64'(vld_o[k]),  64'd0);
            checkOutput({p, "rst_addr"}, 64'(addr_o[k]), 64'd0);
            checkOutput({p, "rst_data"}, 64'(data_o[k]), 64'd0);
            checkOutput({p, "rst_busy"}, 64'(busy_o[k]), 64'd0);
            checkOutput({p, "rst_gid"},  64'(gid_o[k]),  64'd0);
            checkOutput({p, "rst_stat0"}, 64'(stat0_o[k]), 64'd0);
            checkOutput({p, "rst_stat1"}, 64'(stat1_o[k]), 64'd0);
            return;
        end
        v      = req_vld[k];
        acc    = (cyc >= next_free[k]) && (v != 2'b00);
        g      = (v == 2'b11) ? m_prio[k] : v[1];
        e_cmd  = (cyc == acc_cyc[k] + 1);
        e_vld  = (cyc == acc_cyc[k] + 2);
        e_busy = (cyc > acc_cyc[k]) && (cyc < next_free[k]);
        checkOutput({p, "rdy0"}, 64'(rdy0_o[k]), 64'(acc && !g));
        checkOutput({p, "rdy1"}, 64'(rdy1_o[k]), 64'(acc && g));
        checkOutput({p, "cmd"},  64'(cmd_o[k]),  64'(e_cmd));
        checkOutput({p, "addr"}, 64'(addr_o[k]), e_cmd ? 64'(m_addr[k]) : 64'd0);
        checkOutput({p, "vld"},  64'(vld_o[k]),  64'(e_vld));
        checkOutput({p, "data"}, 64'(data_o[k]), e_vld ? 64'(m_data[k]) : 64'd0);
        checkOutput({p, "busy"}, 64'(busy_o[k]), 64'(e_busy));
        checkOutput({p, "gid"},  64'(gid_o[k]),  64'(m_gid[k]));
        checkOutput({p, "stat0"}, 64'(stat0_o[k]), STAT_ON ? 64'(m_cnt0[k]) : 64'd0);
        checkOutput({p, "stat1"}, 64'(stat1_o[k]), STAT_ON ? 64'(m_cnt1[k]) : 64'd0);

        if (cfg_clr[k]) begin
            m_cnt0[k] = '0;
            m_cnt1[k] = '0;
        end else if (acc) begin
            if (!g && m_cnt0[k] != 32'hFFFF_FFFF) m_cnt0[k] = m_cnt0[k] + 1;
            if ( g && m_cnt1[k] != 32'hFFFF_FFFF) m_cnt1[k] = m_cnt1[k] + 1;
        end
        m_acc[k] = 2'b00;
        if (acc) begin
            acc_cyc[k]   = cyc;
            next_free[k] = cyc + 3 + gap;
            m_addr[k]    = req_addr[k][g];
            m_data[k]    = req_data[k][g];
            m_prio[k]    = !g;
            m_gid[k]     = g;
            m_acc[k][g]  = 1'b1;
        end
    endtask

    always @(posedge clk_100m) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk_100m) begin
        for (int k = 0; k < 2; k++) modelStep(k);
    end

    // Requesters keep vld high until accepted; payload only changes on accept.
    task automatic applyStimulus();
        for (int k = 0; k < 2; k++) begin
            cfg_clr[k] = (mode == 0) && ($urandom_range(0, 19) == 0);
            for (int r = 0; r < 2; r++) begin
                logic raise;
                case (mode)
                    0:       raise = ($urandom_range(0, 2) == 0);
                    1:       raise = 1'b1;
                    2:       raise = (r == 1);
                    default: raise = 1'b0;
                endcase
                if (m_acc[k][r] || !req_vld[k][r]) begin
                    req_vld[k][r]  = raise;
                    req_addr[k][r] = $urandom;
                    req_data[k][r] = $urandom;
                end
            end
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk_100m);
            #1;
            applyStimulus();
        end
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 2; k++) begin
            modelReset(k);
            cfg_clr[k] = 1'b0;
            req_vld[k] = 2'b00;
            for (int r = 0; r < 2; r++) begin
                req_addr[k][r] = '0;
                req_data[k][r] = '0;
            end
        end
        rst_100m = 1'b1;
        repeat (3) @(posedge clk_100m);
        #1 rst_100m = 1'b0;
        stepCycles(6);

        // Single req0 transaction with the reference payload
        $display("[TB] single request");
        for (int k = 0; k < 2; k++) begin
            req_vld[k]     = 2'b01;
            req_addr[k][0] = 32'h0000_1234;
            req_data[k][0] = 32'hDEAD_BEEF;
        end
        stepCycles(12);

        $display("[TB] both requesters held");
        mode = 1;
        stepCycles(40);

        $display("[TB] req1 held");
        mode = 2;
        stepCycles(30);

        // Reset in the cycle following the command strobe of instance a
        $display("[TB] reset mid-transaction");
        mode  = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(posedge clk_100m);
            #1;
            applyStimulus();
            if (!req_vld[0][0]) req_vld[0][0] = 1'b1;
            if (cyc == acc_cyc[0] + 2) found = 1'b1;
        end
        checkOutput("rst_mid_wait", 64'(found), 64'd1);
        rst_100m = 1'b1;
        @(posedge clk_100m);
        #1 rst_100m = 1'b0;
        mode = 1;
        applyStimulus();
        stepCycles(20);

        // Clear coinciding with an acceptance on instance a
        $display("[TB] clear on acceptance");
        mode = 2;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_100m);
            #1;
            applyStimulus();
            cfg_clr[0] = (cyc >= next_free[0]) && (i > 20);
        end

        $display("[TB] random traffic");
        mode = 0;
        stepCycles(2500);
        mode = 3;
        stepCycles(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tap_wr_arb.md
TAP_WR_ARB -- requirements
Module: tap_wr_arb

Interface
REQ-001 SHALL have parameter GAP_CYC, default 2, idle cycles inserted after each tap transaction (range 0..15).
REQ-002 SHALL have parameter AW, default 32, tap address width.
REQ-003 SHALL have parameter DW, default 32, tap data width.
REQ-004 SHALL have port clk_100m  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_100m  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cfg_clr  input  1  synchronous clear of statistics counters.
REQ-007 SHALL have ports req0_vld/req1_vld  input  1  requester holds a pending tap write.
REQ-008 SHALL have ports req0_addr/req1_addr  input  AW  and req0_data/req1_data  input  DW  request payload, stable while vld high.
REQ-009 SHALL have ports req0_rdy/req1_rdy  output  1  one-cycle accept strobe.
REQ-010 SHALL have ports tap_wr_cmd  output  1, tap_wr_addr  output  AW, tap_wr_vld  output  1, tap_wr_data  output  DW  tap write channel.
REQ-011 SHALL have ports tap_busy  output  1  (FSM not IDLE) and grant_id  output  1  (requester of current/last transaction).
REQ-012 SHALL have ports stat_cnt0/stat_cnt1  output  32  accepted-transaction counts per requester.

Function
REQ-013 SHALL implement FSM states IDLE, CMD, DATA, GAP.
REQ-014 SHALL, in IDLE with any req_vld high, accept exactly one requester: assert its rdy for one cycle, latch addr/data/id, go to CMD.
REQ-015 SHALL arbitrate round-robin: when both vld, grant the requester not granted last; when one vld, grant it regardless of pointer.
REQ-016 SHALL assert req_rdy only in IDLE and only to the granted requester; never both rdy in one cycle.
REQ-017 SHALL, for acceptance at cycle N, drive tap_wr_cmd=1 with latched address at N+1 and tap_wr_vld=1 with latched data at N+2, each exactly one cycle.
REQ-018 SHALL drive tap_wr_addr and tap_wr_data to zero whenever their strobe is low.
REQ-019 SHALL remain in GAP for exactly GAP_CYC cycles after DATA, then IDLE; GAP_CYC=0 SHALL go DATA->IDLE directly (next acceptance earliest at N+3).
REQ-020 SHALL ignore req_vld changes outside IDLE; requests are never dropped, only delayed.
REQ-021 SHALL increment stat_cnt of the granted requester on the rdy cycle, saturating at 0xFFFFFFFF.
REQ-022 SHALL, when cfg_clr coincides with an acceptance, clear the counter (clear wins); cfg_clr SHALL NOT affect the FSM or an in-flight transaction.
REQ-023 SHALL update grant_id on acceptance and hold it until the next acceptance.

Reset
REQ-024 SHALL, on rst_100m high, immediately force FSM=IDLE, all rdy/strobes/addr/data=0, tap_busy=0, grant_id=0, stat counters=0, RR pointer so req0 wins the first contention.
REQ-025 SHALL abort any in-flight transaction on reset mid-operation with no strobe emitted after reset assertion; the aborted request is not retried.

Configuration
REQ-026 SHALL compile statistics counters only when macro TAP_WR_ARB_STAT_EN is defined; otherwise stat_cnt0/stat_cnt1 SHALL be constant 0, cfg_clr unused, no counter logic present.

Structure
REQ-027 SHALL place FSM state encoding and GAP_CYC range constant in shared package tap_pkg.
REQ-028 SHALL implement the two-way round-robin grant logic as sub-module tap_rr_arb2 (inputs req[1:0], update strobe; output one-hot grant).

Verification
REQ-029 Single req0 (addr 0x0000_1234, data 0xDEAD_BEEF) at cycle 10 -> rdy0 cycle 10, cmd+addr 0x1234 cycle 11, vld+data 0xDEADBEEF cycle 12, busy low cycle 15 (GAP_CYC=2).
REQ-030 req0 and req1 held high continuously for 4 transactions -> grant order 0,1,0,1; acceptances 5 cycles apart; stat_cnt0=2, stat_cnt1=2.
REQ-031 GAP_CYC=0, req1 held high -> acceptances every 3 cycles, no cycle with cmd and vld both high.
REQ-032 rst_100m pulsed in cycle after cmd -> no tap_wr_vld follows; after release first contention grants req0.
REQ-033 cfg_clr in same cycle as req1 acceptance with stat_cnt1=7 -> stat_cnt1=0 next cycle; transaction completes normally.
REQ-034 Build without TAP_WR_ARB_STAT_EN, 3 transactions -> stat_cnt0/stat_cnt1 read 0; tap sequencing identical to REQ-029.
